// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program-counter register and instruction fetch sequencer with flush redirect and memory-timeout fault.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] nextpc_i,
  input  logic        pc_advance_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] outputpc_o,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  output logic        fetch_fault_o
);
  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_FLUSH, S_FAULT} state_t;
  localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d;
  logic        valid_q, valid_d, fault_q, fault_d;
  logic [7:0]  cnt_q, cnt_d;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_FETCH: begin
        if (flush_i) begin
          pc_d    = nextpc_i;
          valid_d = 1'b0;
          cnt_d   = '0;
          state_d = S_FLUSH;
        end else if (imem_ack_i) begin
          instr_d = imem_rdata_i;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = S_HOLD;
        end else if (cnt_q == LAST) begin
          fault_d = 1'b1;
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_HOLD: begin
        if (flush_i) begin
          pc_d    = nextpc_i;
          valid_d = 1'b0;
          cnt_d   = '0;
          state_d = S_FLUSH;
        end else if (pc_advance_i && !stall_i) begin
          pc_d    = nextpc_i;
          valid_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FLUSH: begin
        pc_d    = flush_i ? nextpc_i : pc_q;
        state_d = flush_i ? S_FLUSH : S_FETCH;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end
  // gating with reset kills an in-flight request the moment reset asserts
  assign imem_req_o    = (state_q == S_FETCH) && rst_ni;
  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign outputpc_o    = pc_q + 32'd1;
  assign instr_o       = instr_q;
  assign instr_valid_o = valid_q;
  assign fetch_fault_o = fault_q;
endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: maximum wait cycles for imem_ack before fault; legal range 1..255.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 nextpc  input  32  next-PC value chosen by the branch/jump select mux.
REQ-006 pc_advance  input  1  current instruction retired; load nextpc.
REQ-007 stall  input  1  pipeline hold; blocks pc_advance.
REQ-008 flush  input  1  redirect: discard current or pending fetch and load nextpc.
REQ-009 imem_req  output  1  instruction memory request strobe.
REQ-010 imem_addr  output  32  word address of the request; always equals pc.
REQ-011 imem_ack  input  1  memory response valid, qualifying imem_rdata.
REQ-012 imem_rdata  input  32  fetched instruction word.
REQ-013 pc  output  32  address of the instruction being fetched or held.
REQ-014 outputpc  output  32  sequential successor pc+1, fed back to the select mux.
REQ-015 instr  output  32  latched instruction word.
REQ-016 instr_valid  output  1  instr is valid for the current pc.
REQ-017 fetch_fault  output  1  sticky memory-timeout indication.

Function
REQ-018 States: S_FETCH, S_HOLD, S_FLUSH and S_FAULT, encoded in 2 bits.
REQ-019 outputpc is combinational pc+1, word-addressed, wrapping 32'hFFFF_FFFF -> 32'h0000_0000.
REQ-020 imem_req is 1 only in S_FETCH.
REQ-021 In S_FETCH, wait counter increments each cycle without imem_ack.
REQ-022 In S_FETCH, on imem_ack=1 without flush: instr<=imem_rdata, instr_valid<=1, counter<=0, next state S_HOLD (one-cycle latency from ack to valid).
REQ-023 In S_FETCH, counter reaching TIMEOUT_CYCLES without ack: next state S_FAULT, fetch_fault<=1.
REQ-024 In S_HOLD, with pc_advance=1 and stall=0: pc<=nextpc, instr_valid<=0, next state S_FETCH.
REQ-025 In S_HOLD, with stall=1 or pc_advance=0: pc, instr and instr_valid hold.
REQ-026 flush=1 in S_FETCH or S_HOLD has priority over ack, advance and stall: pc<=nextpc, instr_valid<=0, counter<=0, next state S_FLUSH.
REQ-027 An ack arriving in the same cycle as flush is discarded; instr is not updated.
REQ-028 S_FLUSH lasts exactly one cycle with imem_req=0, so an aborted request is never extended; next state S_FETCH.
REQ-029 flush in S_FLUSH reloads pc<=nextpc and stays in S_FLUSH for one further cycle.
REQ-030 S_FAULT is terminal until reset; imem_req=0, instr_valid=0, and flush and advance are ignored.
REQ-031 imem_ack outside S_FETCH is ignored.
REQ-032 pc changes only on advance (REQ-024) or flush (REQ-026, REQ-029).

Reset
REQ-033 reset=0 forces immediately, without a clock: pc=RESET_PC, instr=0, instr_valid=0, fetch_fault=0, counter=0, state S_FETCH.
REQ-034 Reset asserted mid-request drops imem_req in the same cycle; a later ack is ignored until the first post-reset request.
REQ-035 The first request is issued on the first clock edge after reset deasserts, with imem_addr=RESET_PC.

Verification
REQ-036 Reset release, ack after 2 cycles with rdata=32'hDEAD_BEEF -> instr=32'hDEAD_BEEF, instr_valid=1, pc=0, outputpc=1.
REQ-037 In S_HOLD with pc_advance=1, stall=1 for 3 cycles, then stall=0 with nextpc=32'h40 -> pc holds at 0, then pc=32'h40 and imem_req=1 on the next cycle.
REQ-038 flush=1 with imem_ack=1 in the same S_FETCH cycle, nextpc=32'h100 -> instr unchanged, imem_req=0 for 1 cycle, then imem_addr=32'h100.
REQ-039 No ack for TIMEOUT_CYCLES=4 -> fetch_fault=1 after 4 cycles and imem_req=0; fault persists through flush and clears only on reset.
REQ-040 pc=32'hFFFF_FFFF -> outputpc=32'h0000_0000; advance with nextpc=outputpc -> pc=0.
REQ-041 reset=0 asserted asynchronously between clock edges during S_HOLD -> instr_valid=0 and pc=RESET_PC before the next edge.
